rr_mux4_stream: RTL and testbench
=================================

Name: rr_mux4_stream

Overview:
- 4-to-1 streaming multiplexer: the gather side of the 1-to-4 demux datapath (d, s -> y[3:0]).
- Four independent valid/ready input channels are merged into one registered output stream.
- Round-robin arbitration decides which channel is served. Each output word carries the 2-bit source index `s`, so a downstream demux can route it back.
- Sits between per-lane producers and a shared serial link or demux.

Parameters:
- WIDTH, 8, data bits per channel word.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d_in  input  4*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- v_in  input  4  per-channel valid.
- r_in  output  4  per-channel ready (combinational).
- y  output  WIDTH  registered output data.
- s  output  2  registered source channel index of y.
- v_out  output  1  output valid.
- r_out  input  1  downstream ready.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high and is sampled only on the clk rising edge.
- Reset values:
  - y=0, s=0, v_out=0.
  - Round-robin pointer last=3, so channel 0 has highest priority first.
  - Output state = EMPTY.
- Output register FSM, two states:
  - EMPTY (v_out=0): may load.
  - FULL (v_out=1): loads only if r_out=1 in the same cycle.
- load_en = (state==EMPTY) | r_out.
- Arbitration (combinational):
  - Search order is last+1, last+2, last+3, last (mod 4).
  - grant = first channel in that order with v_in set.
  - No valid input -> no grant.
- r_in[i] = load_en & (grant==i). At most one r_in bit is high per cycle.
- r_in never depends on v_in[i] of the same channel except through arbitration. Producers must not wait for r_in before asserting valid.
- Transfer on input i: v_in[i] & r_in[i] at the clock edge. On that edge:
  - y <= d_in[i], s <= i, v_out <= 1, last <= i, state -> FULL.
- Output transfer: v_out & r_out.
  - If load_en and no grant: v_out <= 0, state -> EMPTY. y and s hold their last values.
- Stall: while v_out=1 and r_out=0, y, s and v_out are held bit-stable and all r_in=0.
- Latency: 1 cycle from input acceptance to v_out.
- Throughput: 1 word per cycle when r_out stays high. A simultaneous output pop and input load in FULL is permitted, with no bubble.
- Fairness: with all four channels continuously valid and r_out=1, grants cycle 0,1,2,3,0,... Starvation-free, worst-case wait is 3 grants.
- last updates only on an accepted input transfer. It is unchanged during stalls and idle cycles.
- Mid-operation reset:
  - A word held in FULL is discarded: v_out=0 on the next cycle.
  - r_in is forced to 0 during the cycle rst is high.
  - Pointer returns to last=3.
- Width rule: the s index wraps mod 4 (2-bit arithmetic); no other arithmetic.
- No X propagation: y is defined from reset.

Test Plan:
- Reset: rst=1 for 2 cycles with v_in=4'b1111 -> r_in=0, v_out=0, y=0, s=0 throughout; after release the first grant is channel 0.
- Single channel: WIDTH=8, v_in=4'b0100, d_in lane2=8'hA5, r_out=1 -> r_in=4'b0100; next cycle y=8'hA5, s=2, v_out=1. Then v_in=0 -> v_out=0 one cycle later.
- Round-robin: lanes hold 8'h10, 8'h21, 8'h32, 8'h43, v_in=4'b1111, r_out=1 for 8 cycles -> s sequence 0,1,2,3,0,1,2,3 with matching y, back-to-back, v_out continuously 1.
- Backpressure: load lane1=8'h5C, then r_out=0 for 3 cycles with v_in=4'b1111 -> y=8'h5C, s=1 held stable, r_in=0. When r_out=1, next word is from channel 2.
- Skip idle channels: after a grant to channel 3, v_in=4'b0010 -> grant channel 1. Then v_in=4'b1011 -> grant channel 3 (search 2,3,0,1).
- Reset mid-stream: v_out=1 with r_out=0, assert rst for 1 cycle -> v_out=0 next cycle. With v_in=4'b1000 afterwards, channel 3 is granted and the pointer restarts at last=3.

Source files
------------

// File: rtl/rr_mux4_stream.sv
// ============================================================================
// rr_mux4_stream : round-robin 4-to-1 valid/ready merge into a registered stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_mux4_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] d_in,
    input  logic [3:0]         v_in,
    output logic [3:0]         r_in,
    output logic [WIDTH-1:0]   y,
    output logic [1:0]         s,
    output logic               v_out,
    input  logic               r_out
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_last;
    logic [WIDTH-1:0]   r_y;
    logic [1:0]         r_s;

    logic               w_load_en;
    logic               w_gnt_vld;
    logic [1:0]         w_gnt;
    logic               w_load;
    logic [WIDTH-1:0]   w_data;

    // Search starts one past the last served channel; the 2-bit sum wraps mod 4.
    always_comb begin
        logic [1:0] idx;
        w_gnt_vld = 1'b0;
        w_gnt     = 2'd0;
        idx       = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!w_gnt_vld && v_in[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = idx;
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_gnt == 2'(i)) begin
                w_data = d_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_load_en = (r_state == ST_EMPTY) | r_out;
    assign w_load    = w_load_en & w_gnt_vld & ~rst;

    always_comb begin
        r_in = 4'b0000;
        if (w_load) begin
            r_in[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ST_FULL;
        end else if (w_load_en) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_last  <= 2'd3;
            r_y     <= '0;
            r_s     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_y    <= w_data;
                r_s    <= w_gnt;
                r_last <= w_gnt;
            end
        end
    end

    assign y     = r_y;
    assign s     = r_s;
    assign v_out = (r_state == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4_stream.sv
// ============================================================================
// tb_rr_mux4_stream : directed table-driven bench for rr_mux4_stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux4_stream;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [4*WIDTH-1:0] d_in;
    logic [3:0]         v_in;
    logic [3:0]         r_in;
    logic [WIDTH-1:0]   y;
    logic [1:0]         s;
    logic               v_out;
    logic               r_out;

    int passed;
    int total;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic        ro;
        logic [3:0]  er;
        logic        ev;
        logic [7:0]  ey;
        logic [1:0]  es;
    } vec_t;

    vec_t vecs[$];

    rr_mux4_stream #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .v_in  (v_in),
        .r_in  (r_in),
        .y     (y),
        .s     (s),
        .v_out (v_out),
        .r_out (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic [3:0] v, input logic [31:0] d, input logic ro,
                       input logic [3:0] er, input logic ev, input logic [7:0] ey, input logic [1:0] es);
        vec_t t;
        t.rst = rs; t.v = v; t.d = d; t.ro = ro;
        t.er = er; t.ev = ev; t.ey = ey; t.es = es;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, then check outputs as seen before the next rising edge.
    task automatic step(input int row, input vec_t t);
        @(negedge clk);
        rst   = t.rst;
        v_in  = t.v;
        d_in  = t.d;
        r_out = t.ro;
        #1;
        check("r_in",  row, 32'(r_in),  32'(t.er));
        check("v_out", row, 32'(v_out), 32'(t.ev));
        check("y",     row, 32'(y),     32'(t.ey));
        check("s",     row, 32'(s),     32'(t.es));
    endtask

    initial begin
        vec_t t;
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        v_in   = 4'b0000;
        d_in   = '0;
        r_out  = 1'b1;
        @(posedge clk);

        // reset held with all channels valid
        add(1, 4'b1111, 32'h43322110, 1, 4'b0000, 0, 8'h00, 2'd0);
        add(1, 4'b1111, 32'h43322110, 1, 4'b0000, 0, 8'h00, 2'd0);
        // round-robin, eight back-to-back grants
        add(0, 4'b1111, 32'h43322110, 1, 4'b0001, 0, 8'h00, 2'd0);
        add(0, 4'b1111, 32'h43322110, 1, 4'b0010, 1, 8'h10, 2'd0);
        add(0, 4'b1111, 32'h43322110, 1, 4'b0100, 1, 8'h21, 2'd1);
        add(0, 4'b1111, 32'h43322110, 1, 4'b1000, 1, 8'h32, 2'd2);
        add(0, 4'b1111, 32'h43322110, 1, 4'b0001, 1, 8'h43, 2'd3);
        add(0, 4'b1111, 32'h43322110, 1, 4'b0010, 1, 8'h10, 2'd0);
        add(0, 4'b1111, 32'h43322110, 1, 4'b0100, 1, 8'h21, 2'd1);
        add(0, 4'b1111, 32'h43322110, 1, 4'b1000, 1, 8'h32, 2'd2);
        add(0, 4'b0000, 32'h43322110, 1, 4'b0000, 1, 8'h43, 2'd3);
        add(0, 4'b0000, 32'h43322110, 1, 4'b0000, 0, 8'h43, 2'd3);
        // single channel 2
        add(0, 4'b0100, 32'h00A50000, 1, 4'b0100, 0, 8'h43, 2'd3);
        add(0, 4'b0000, 32'h00A50000, 1, 4'b0000, 1, 8'hA5, 2'd2);
        add(0, 4'b0000, 32'h00A50000, 1, 4'b0000, 0, 8'hA5, 2'd2);
        // backpressure on a word from channel 1
        add(0, 4'b0010, 32'h00005C00, 1, 4'b0010, 0, 8'hA5, 2'd2);
        add(0, 4'b1111, 32'h44332211, 0, 4'b0000, 1, 8'h5C, 2'd1);
        add(0, 4'b1111, 32'h44332211, 0, 4'b0000, 1, 8'h5C, 2'd1);
        add(0, 4'b1111, 32'h44332211, 0, 4'b0000, 1, 8'h5C, 2'd1);
        add(0, 4'b1111, 32'h44332211, 1, 4'b0100, 1, 8'h5C, 2'd1);
        add(0, 4'b0000, 32'h44332211, 1, 4'b0000, 1, 8'h33, 2'd2);
        add(0, 4'b0000, 32'h44332211, 1, 4'b0000, 0, 8'h33, 2'd2);
        // skip idle channels
        add(0, 4'b1000, 32'h44332211, 1, 4'b1000, 0, 8'h33, 2'd2);
        add(0, 4'b0010, 32'h44332211, 1, 4'b0010, 1, 8'h44, 2'd3);
        add(0, 4'b1011, 32'h44332211, 1, 4'b1000, 1, 8'h22, 2'd1);
        add(0, 4'b0000, 32'h44332211, 1, 4'b0000, 1, 8'h44, 2'd3);
        add(0, 4'b0000, 32'h44332211, 1, 4'b0000, 0, 8'h44, 2'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i]);
        end

        // Mid-stream reset: a stalled word from channel 0 is discarded and the pointer restarts at 3.
        t.d = 32'h44332211;
        t.rst = 0; t.v = 4'b0001; t.ro = 1; t.er = 4'b0001; t.ev = 0; t.ey = 8'h44; t.es = 2'd3;
        step(100, t);
        t.rst = 0; t.v = 4'b0000; t.ro = 0; t.er = 4'b0000; t.ev = 1; t.ey = 8'h11; t.es = 2'd0;
        step(101, t);
        t.rst = 1; t.v = 4'b1111; t.ro = 0; t.er = 4'b0000; t.ev = 1; t.ey = 8'h11; t.es = 2'd0;
        step(102, t);
        t.rst = 0; t.v = 4'b1000; t.ro = 0; t.er = 4'b1000; t.ev = 0; t.ey = 8'h00; t.es = 2'd0;
        step(103, t);
        t.rst = 0; t.v = 4'b1111; t.ro = 1; t.er = 4'b0001; t.ev = 1; t.ey = 8'h44; t.es = 2'd3;
        step(104, t);
        t.rst = 0; t.v = 4'b0000; t.ro = 1; t.er = 4'b0000; t.ev = 1; t.ey = 8'h11; t.es = 2'd0;
        step(105, t);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
